// File: rtl/stack_proc_defs.sv
// Shared constants for the stack processor: PC width, return-stack depth and
// the width of an occupancy counter that must be able to hold the value DEPTH.
package stack_proc_defs;

  localparam int PC_W      = 16;
  localparam int RAS_DEPTH = 16;

  // One extra bit so a counter can hold the value "depth" itself.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ras_regfile.sv
// Return-address storage: one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset.
module ras_regfile
  import stack_proc_defs::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Hardware return-address stack: push on call, pop on return, replace-top on
// tail call. Define RAS_WRAP_EN to make the stack circular (push while full
// overwrites the oldest entry instead of being dropped).
module return_addr_stack
  import stack_proc_defs::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  input  logic                      Push,
  input  logic                      Pop,
  input  logic [AW-1:0]             PCin,
  output logic [AW-1:0]             PCout,
  output logic                      Empty,
  output logic                      Full,
  output logic [count_w(DEPTH)-1:0] Count,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  // ptr indexes the current top entry; its natural wrap gives modulo-DEPTH math.
  logic [PW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf, unf;
  logic          ovf_set, unf_set;
  logic          we;
  logic [PW-1:0] waddr;
  logic [AW-1:0] rdata;

  assign Empty     = (cnt == '0);
  assign Full      = (cnt == CW'(DEPTH));
  assign Count     = cnt;
  assign Overflow  = ovf;
  assign Underflow = unf;
  assign PCout     = Empty ? '0 : rdata;

  always_comb begin
    we      = 1'b0;
    waddr   = ptr;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (Push && Pop) begin
      if (Empty) begin
        we      = 1'b1;
        waddr   = ptr + PW'(1);
        ptr_nxt = ptr + PW'(1);
        cnt_nxt = cnt + CW'(1);
        unf_set = 1'b1;
      end else begin
        // Tail call: the callee's return replaces ours in place.
        we    = 1'b1;
        waddr = ptr;
      end
    end else if (Push) begin
      if (!Full) begin
        we      = 1'b1;
        waddr   = ptr + PW'(1);
        ptr_nxt = ptr + PW'(1);
        cnt_nxt = cnt + CW'(1);
      end else begin
`ifdef RAS_WRAP_EN
        // ptr+1 is the oldest slot when full, so this evicts it.
        we      = 1'b1;
        waddr   = ptr + PW'(1);
        ptr_nxt = ptr + PW'(1);
`else
        ovf_set = 1'b1;
`endif
      end
    end else if (Pop) begin
      if (!Empty) begin
        ptr_nxt = ptr - PW'(1);
        cnt_nxt = cnt - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

  ras_regfile #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_regfile (
    .clk  (CLK),
    .we   (we),
    .waddr(waddr),
    .wdata(PCin),
    .raddr(ptr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: reset, push/pop ordering, tail call,
// underflow/overflow stickiness, full-stack behaviour and reset priority.
module tb_return_addr_stack;

  logic        clk;
  logic        reset_n;
  logic        push;
  logic        pop;
  logic [15:0] pc_in;
  logic [15:0] pc_out;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  return_addr_stack dut (
    .CLK      (clk),
    .Reset_n  (reset_n),
    .Push     (push),
    .Pop      (pop),
    .PCin     (pc_in),
    .PCout    (pc_out),
    .Empty    (empty),
    .Full     (full),
    .Count    (count),
    .Overflow (overflow),
    .Underflow(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample #1 after the edge.
  task automatic drive_cycle(input logic rst_n, input logic psh, input logic pp,
                             input logic [15:0] pc);
    @(negedge clk);
    reset_n = rst_n;
    push    = psh;
    pop     = pp;
    pc_in   = pc;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    pc_in   = '0;

    // 1: reset then idle
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("rst_pcout", pc_out, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // 2: push three, pop three
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0011);
    check("p1_pcout", pc_out, 16'h0011);
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0022);
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0033);
    check("p3_pcout", pc_out, 16'h0033);
    check("p3_count", count, 3);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    check("pop1_pcout", pc_out, 16'h0022);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    check("pop2_pcout", pc_out, 16'h0011);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    check("pop3_empty", empty, 1);
    check("pop3_pcout", pc_out, 0);
    check("pop3_unf", underflow, 0);

    // 3: tail call
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0100);
    drive_cycle(1'b1, 1'b1, 1'b1, 16'h0200);
    check("tail_count", count, 1);
    check("tail_pcout", pc_out, 16'h0200);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    check("tail_pop_empty", empty, 1);

    // 4: underflow is sticky
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    check("unf_count", count, 0);
    check("unf_flag", underflow, 1);
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0055);
    check("unf_sticky", underflow, 1);
    check("unf_push_pcout", pc_out, 16'h0055);
    drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    // push+pop while empty acts as push and flags underflow
    do_reset();
    check("unf_cleared", underflow, 0);
    drive_cycle(1'b1, 1'b1, 1'b1, 16'h0066);
    check("pp_empty_count", count, 1);
    check("pp_empty_pcout", pc_out, 16'h0066);
    check("pp_empty_unf", underflow, 1);

    // 5: fill to DEPTH, then push once more
    do_reset();
    for (int i = 1; i <= 16; i++) drive_cycle(1'b1, 1'b1, 1'b0, 16'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_pcout", pc_out, 16'h0010);
    check("fill_ovf", overflow, 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h0011);
`ifdef RAS_WRAP_EN
    check("wrap_pcout", pc_out, 16'h0011);
    check("wrap_count", count, 16);
    check("wrap_ovf", overflow, 0);
    exp_q.push_back(16'h0011);
    for (int v = 16; v >= 2; v--) exp_q.push_back(16'(v));
`else
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_pcout", pc_out, 16'h0010);
    check("ovf_count", count, 16);
    exp_q.push_back(16'h0010);
    for (int v = 15; v >= 1; v--) exp_q.push_back(16'(v));
`endif
    // Push+Pop while full replaces the top and never flags overflow.
    drive_cycle(1'b1, 1'b1, 1'b1, 16'h0077);
    check("full_pp_pcout", pc_out, 16'h0077);
    check("full_pp_count", count, 16);
`ifdef RAS_WRAP_EN
    check("full_pp_ovf", overflow, 0);
`else
    check("full_pp_ovf", overflow, 1);
`endif
    void'(exp_q.pop_front());
    exp_q.push_front(16'h0077);
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("drain_pcout", pc_out, e);
      drive_cycle(1'b1, 1'b0, 1'b1, 16'h0);
    end
    check("drain_empty", empty, 1);
    check("drain_unf", underflow, 0);

    // 6: reset wins over a simultaneous push
    drive_cycle(1'b1, 1'b1, 1'b0, 16'h1234);
    check("pre_rst_count", count, 1);
    drive_cycle(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("rstpush_count", count, 0);
    check("rstpush_empty", empty, 1);
    check("rstpush_pcout", pc_out, 0);
    check("rstpush_ovf", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
